scie_fir_driver: RTL and testbench
==================================

# scie_fir_driver

Command-side sequencer for the SCIE complex-FIR custom-instruction unit `SCIEPipelined`. It accepts complex tap pairs over a valid/ready stream and drives the `io_insn`/`io_rs1`/`io_rs2`/`io_valid` instruction stream that loads them into the unit. It then issues the compute instruction, captures `io_rd` after the unit's fixed latency and returns the result on a valid/ready output. It stands in for the RISC-V core when the FIR is exercised standalone.

## Interface
- `TAPS`, 5: complex tap pairs per job; tap index width `IDX_W = $clog2(TAPS)`, minimum 1.
- `DATA_W`, 32: operand and result width (signed Q16.16).
- `RESULT_LAT`, 1: cycles from the compute-issue cycle to the cycle `scie_rd` is valid; must be 1 or more.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in_valid`  in  1: tap pair offered.
- `in_ready`  out  1: driver accepts a tap pair.
- `in_re`  in  DATA_W: signed real part.
- `in_im`  in  DATA_W: signed imaginary part.
- `scie_insn`  out  32: instruction word to the SCIE unit.
- `scie_rs1`  out  DATA_W: operand value.
- `scie_rs2`  out  32: tap index, zero-extended.
- `scie_valid`  out  1: instruction valid.
- `scie_rd`  in  DATA_W: SCIE result.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out_data`  out  DATA_W: captured FIR result.

## Operation
- Opcodes:
  - `LOAD_RE` = 0x0000000B
  - `LOAD_IM` = 0x0000002B
  - `COMPUTE` = 0x0000005B
- FSM states: IDLE, ISSUE_RE, ISSUE_IM, COMPUTE, WAIT, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch `in_re` and `in_im` into an internal pair register, then go to ISSUE_RE.
- ISSUE_RE: drive `scie_valid`=1, `insn`=LOAD_RE, `rs1`=latched re, `rs2`=idx. Go to ISSUE_IM.
- ISSUE_IM: drive `scie_valid`=1, `insn`=LOAD_IM, `rs1`=latched im, `rs2`=idx (same index).
  - If idx==TAPS-1: go to COMPUTE.
  - Otherwise: idx+=1, go to IDLE.
- COMPUTE:
  - Drive `scie_valid`=1, `insn`=COMPUTE, `rs1`=latched im (held), `rs2`=idx (held).
  - Load the wait counter with RESULT_LAT-1, go to WAIT.
- WAIT:
  - `scie_valid`=0; insn, rs1 and rs2 hold their last values.
  - When the counter is 0: capture `scie_rd` into `out_data`, go to OUT. Otherwise decrement the counter.
- OUT:
  - `out_valid`=1.
  - On `out_ready`: clear idx to 0, go to IDLE.
  - `out_data` is stable while `out_valid`=1.
- All `scie_*` and `out_*` outputs are registered.
- `in_ready` is a decode of state IDLE, so there is no combinational path from `in_valid`.
- Arithmetic:
  - No arithmetic on data; values pass through bit-exact.
  - idx wraps only via the explicit clear in OUT.
  - `scie_rs2` = {zeros, idx}.

## Timing
- Reset values:
  - state=IDLE, idx=0, counter=0.
  - `scie_valid`=0, `scie_insn`=0, `scie_rs1`=0, `scie_rs2`=0.
  - `out_valid`=0, `out_data`=0.
  - `in_ready`=1 once reset deasserts.
- Handshake: a tap is accepted when `in_valid` && `in_ready` at the edge. The LOAD_RE instruction appears on the following cycle, and LOAD_IM one cycle after that.
- Throughput is one tap per 3 cycles, accounting for the IDLE accept cycle.
- Job latency, from the last-tap accept edge to `out_valid`=1, is 3+RESULT_LAT cycles.
- `in_valid` held high continuously: taps are accepted back-to-back with no bubbles beyond the FSM cadence.
- `in_valid` asserted while `out_valid`=1: no accept; `in_ready`=0 until the result is taken.
- `out_ready` held low: OUT holds indefinitely and `scie_valid` stays 0.
- `out_ready` high on the same edge that OUT is entered: no effect. The result is taken on the next edge at the earliest.
- Reset asserted mid-job: immediately return to reset values. Partially loaded taps are abandoned, and the next job starts at idx 0.

## Structure
- Package `scie_pkg`:
  - opcode constants LOAD_RE, LOAD_IM, COMPUTE;
  - state enum `drv_state_t`;
  - default DATA_W.
- No sub-modules are needed. The pair register, idx counter, wait counter and FSM sit in one module of about 150–200 lines.
- Shared with the SCIE decode, which uses the same package constants.

## Test plan
- Reference job: pair the driver with `SCIEPipelined`. Feed the taps (19661,157286), (-26214,-91750), (72090,111411), (45875,216269), (137626,6554) with `in_valid` held high.
  - Required `scie` stream: insn 11/43 pairs with rs2 = 0..4, then insn 91.
  - Required result: `out_data`=304089, with `out_valid` asserted exactly 4 cycles after the 5th accept.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_data` stays stable; `in_ready`=0; `scie_valid`=0 throughout.
  - Release `out_ready`: `in_ready`=1 on the next cycle.
- Bubbly input: insert random 0–5 cycle gaps in `in_valid`.
  - The instruction sequence and result are identical to the reference job.
  - No `scie_valid` pulse occurs without a preceding accept.
- Reset mid-job: assert `reset` asynchronously after the 3rd tap's LOAD_RE.
  - All outputs clear within the same cycle.
  - A subsequent full reference job again yields 304089 with rs2 starting at 0.
- Parameter sweep: TAPS=1 and RESULT_LAT=3 against a behavioural SCIE model.
  - Latency is 6 cycles.
  - Only rs2=0 is issued.
  - COMPUTE appears right after the first LOAD_IM.

Source files
------------

// File: rtl/scie_pkg.sv
// ----------------------------------------------------------------------------
// scie_pkg
//   Shared constants and types for the SCIE complex-FIR command path. The
//   opcode values are also used by the SCIE decode, so they live here rather
//   than inside the driver.
//
//   Contents:
//     SCIE_DATA_W  default operand/result width (signed Q16.16)
//     LOAD_RE      instruction word that loads a tap real part
//     LOAD_IM      instruction word that loads a tap imaginary part
//     COMPUTE      instruction word that runs the FIR over the loaded taps
//     drv_state_t  driver sequencer states
// ----------------------------------------------------------------------------
package scie_pkg;

   localparam int SCIE_DATA_W = 32;

   localparam logic [31:0] LOAD_RE = 32'h0000_000B;
   localparam logic [31:0] LOAD_IM = 32'h0000_002B;
   localparam logic [31:0] COMPUTE = 32'h0000_005B;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_RE,
      S_ISSUE_IM,
      S_COMPUTE,
      S_WAIT,
      S_OUT
   } drv_state_t;

endpackage : scie_pkg

// File: rtl/scie_fir_driver_if.sv
// ----------------------------------------------------------------------------
// scie_fir_driver_if
//   Bundles the three streams around the FIR driver: the tap input stream,
//   the instruction stream towards the SCIE unit, and the result output
//   stream.
//
//   Signals:
//     in_valid / in_ready       tap pair handshake
//     in_re / in_im             signed tap real / imaginary part
//     scie_insn                 instruction word to the SCIE unit
//     scie_rs1                  operand value
//     scie_rs2                  tap index, zero-extended
//     scie_valid                instruction valid
//     scie_rd                   SCIE result
//     out_valid / out_ready     result handshake
//     out_data                  captured FIR result
//
//   Modports:
//     master  the driver side (drives in_ready, scie_* commands, out_*)
//     slave   the environment side (tap source, SCIE unit, result sink)
// ----------------------------------------------------------------------------
interface scie_fir_driver_if
   import scie_pkg::*;
#(
   parameter int DATA_W = SCIE_DATA_W
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_re;
   logic signed [DATA_W-1:0] in_im;

   logic [31:0]              scie_insn;
   logic [DATA_W-1:0]        scie_rs1;
   logic [31:0]              scie_rs2;
   logic                     scie_valid;
   logic [DATA_W-1:0]        scie_rd;

   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_data;

   modport master (
      input  in_valid, in_re, in_im, scie_rd, out_ready,
      output in_ready, scie_insn, scie_rs1, scie_rs2, scie_valid,
             out_valid, out_data
   );

   modport slave (
      output in_valid, in_re, in_im, scie_rd, out_ready,
      input  in_ready, scie_insn, scie_rs1, scie_rs2, scie_valid,
             out_valid, out_data
   );

endinterface : scie_fir_driver_if

// File: rtl/scie_fir_driver.sv
// ----------------------------------------------------------------------------
// scie_fir_driver
//   Command-side sequencer for the SCIE complex-FIR unit. Accepts TAPS complex
//   tap pairs, loads each one into the unit as a LOAD_RE / LOAD_IM instruction
//   pair carrying the tap index, then issues COMPUTE, captures scie_rd
//   RESULT_LAT cycles after the compute issue and offers it on the output
//   stream until taken.
//
//   Parameters:
//     TAPS        complex tap pairs per job (>= 1)
//     DATA_W      operand / result width
//     RESULT_LAT  cycles from compute issue to scie_rd valid (>= 1)
//
//   Ports:
//     clock   rising-edge clock
//     reset   asynchronous, active-high reset
//     bus     scie_fir_driver_if.master (tap input, SCIE command, result out)
// ----------------------------------------------------------------------------
module scie_fir_driver
   import scie_pkg::*;
#(
   parameter int TAPS       = 5,
   parameter int DATA_W     = SCIE_DATA_W,
   parameter int RESULT_LAT = 1
) (
   input  logic               clock,
   input  logic               reset,
   scie_fir_driver_if.master  bus
);

   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TAPS - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RESULT_LAT - 1);

   drv_state_t        state_q,      state_d;
   logic [IDX_W-1:0]  idx_q,        idx_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [DATA_W-1:0] re_q,         re_d;
   logic [DATA_W-1:0] im_q,         im_d;
   logic [31:0]       insn_q,       insn_d;
   logic [DATA_W-1:0] rs1_q,        rs1_d;
   logic [31:0]       rs2_q,        rs2_d;
   logic              scie_valid_q, scie_valid_d;
   logic              out_valid_q,  out_valid_d;
   logic [DATA_W-1:0] out_data_q,   out_data_d;

   // --------------------------------------------------------------------------
   // Next-state and output decode.
   // The scie_* and out_* outputs are registers, so each instruction is set up
   // on the transition INTO the state that presents it: the LOAD_RE word is
   // loaded on the accept edge, LOAD_IM on the edge into ISSUE_IM, and so on.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned; an unassigned path would infer a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      re_d         = re_q;
      im_d         = im_q;
      insn_d       = insn_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      scie_valid_d = 1'b0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;

      unique case (state_q)
         S_IDLE: begin
            // in_ready is the IDLE decode, so in_valid alone means accept.
            if (bus.in_valid) begin
               re_d         = bus.in_re;
               im_d         = bus.in_im;
               scie_valid_d = 1'b1;
               insn_d       = LOAD_RE;
               rs1_d        = bus.in_re;
               rs2_d        = 32'(idx_q);
               state_d      = S_ISSUE_RE;
            end
         end

         S_ISSUE_RE: begin
            scie_valid_d = 1'b1;
            insn_d       = LOAD_IM;
            rs1_d        = im_q;
            state_d      = S_ISSUE_IM;
         end

         S_ISSUE_IM: begin
            if (idx_q == LAST_IDX) begin
               // COMPUTE keeps rs1/rs2 at the last LOAD_IM operands.
               scie_valid_d = 1'b1;
               insn_d       = COMPUTE;
               state_d      = S_COMPUTE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_IDLE;
            end
         end

         S_COMPUTE: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (cnt_q == '0) begin
               out_data_d  = bus.scie_rd;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_OUT: begin
            // out_ready is only looked at while OUT is the current state, so a
            // consumer that is already ready when OUT is entered takes the
            // result one edge later.
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               idx_d       = '0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and output registers. Reset abandons any partially loaded job.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         re_q         <= '0;
         im_q         <= '0;
         insn_q       <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         scie_valid_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         re_q         <= re_d;
         im_q         <= im_d;
         insn_q       <= insn_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         scie_valid_q <= scie_valid_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.scie_insn  = insn_q;
   assign bus.scie_rs1   = rs1_q;
   assign bus.scie_rs2   = rs2_q;
   assign bus.scie_valid = scie_valid_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;

endmodule : scie_fir_driver

// File: tb/tb_scie_fir_driver.sv
// ----------------------------------------------------------------------------
// tb_scie_fir_driver
//   Directed bench for scie_fir_driver. Instance A uses the default
//   parameters (TAPS=5, RESULT_LAT=1); instance B uses TAPS=1, RESULT_LAT=3.
//   A behavioural SCIE stand-in drives scie_rd with the job result only in
//   the cycle it is due and with a poison value otherwise, so a capture on
//   the wrong cycle is visible.
// ----------------------------------------------------------------------------
module tb_scie_fir_driver;
   import scie_pkg::*;

   localparam int          DW         = 32;
   localparam logic [31:0] REF_RESULT = 32'd304089;
   localparam logic [31:0] SWP_RESULT = 32'h1357_9BDF;
   localparam logic [31:0] POISON     = 32'hDEAD_BEEF;
   localparam int          LAT_B      = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic signed [31:0] tap_re [5] = '{19661, -26214, 72090, 45875, 137626};
   logic signed [31:0] tap_im [5] = '{157286, -91750, 111411, 216269, 6554};

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   scie_fir_driver_if #(.DATA_W(DW)) bus_a ();
   scie_fir_driver_if #(.DATA_W(DW)) bus_b ();

   scie_fir_driver #(.TAPS(5), .DATA_W(DW), .RESULT_LAT(1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   scie_fir_driver #(.TAPS(1), .DATA_W(DW), .RESULT_LAT(LAT_B)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   // SCIE stand-in for A: result valid in the cycle right after the compute
   // issue cycle (latency 1).
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_a.scie_rd <= POISON;
      end else if (bus_a.scie_valid && bus_a.scie_insn == COMPUTE) begin
         bus_a.scie_rd <= REF_RESULT;
      end else begin
         bus_a.scie_rd <= POISON;
      end
   end

   // SCIE stand-in for B: result valid LAT_B cycles after the compute issue
   // cycle, for exactly one cycle.
   int cd_b;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_b.scie_rd <= POISON;
         cd_b          <= 0;
      end else if (bus_b.scie_valid && bus_b.scie_insn == COMPUTE) begin
         bus_b.scie_rd <= POISON;
         cd_b          <= LAT_B - 1;
      end else if (cd_b == 1) begin
         bus_b.scie_rd <= SWP_RESULT;
         cd_b          <= 0;
      end else begin
         bus_b.scie_rd <= POISON;
         if (cd_b > 1) cd_b <= cd_b - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_a_cleared(input string phase);
      check({phase, "_scie_valid"}, 32'(bus_a.scie_valid), 32'd0);
      check({phase, "_scie_insn"},  bus_a.scie_insn,       32'd0);
      check({phase, "_scie_rs1"},   bus_a.scie_rs1,        32'd0);
      check({phase, "_scie_rs2"},   bus_a.scie_rs2,        32'd0);
      check({phase, "_out_valid"},  32'(bus_a.out_valid),  32'd0);
      check({phase, "_out_data"},   bus_a.out_data,        32'd0);
      check({phase, "_in_ready"},   32'(bus_a.in_ready),   32'd1);
   endtask

   // Feeds the five reference taps into A and checks the instruction stream,
   // the accept-before-issue ordering, the job latency and the result. With
   // abort_ev >= 0 it returns right after that many instructions were seen.
   task automatic run_job(input bit bubbly, input int abort_ev);
      logic [31:0] e_insn, e_rs1, e_rs2;
      int  t, ev, gap, acc_cyc;
      bit  acc, got_out;
      t = 0; ev = 0; gap = 0; acc_cyc = 0; got_out = 0;
      for (int b = 0; b < 200 && !got_out; b++) begin
         if (t < 5 && gap == 0) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_re    = tap_re[t];
            bus_a.in_im    = tap_im[t];
         end else begin
            bus_a.in_valid = 1'b0;
            if (gap > 0) gap--;
         end
         acc = bus_a.in_valid && bus_a.in_ready;
         step();
         if (acc) begin
            t++;
            acc_cyc = cyc;
            if (bubbly) gap = $urandom_range(0, 5);
         end
         if (bus_a.scie_valid) begin
            if (ev < 10) begin
               e_insn = (ev % 2 == 1) ? LOAD_IM : LOAD_RE;
               e_rs1  = (ev % 2 == 1) ? tap_im[ev/2] : tap_re[ev/2];
               e_rs2  = 32'(ev / 2);
               if (ev % 2 == 0) check("load_after_accept", 32'(t), 32'(ev / 2 + 1));
            end else begin
               e_insn = COMPUTE;
               e_rs1  = tap_im[4];
               e_rs2  = 32'd4;
               check("no_extra_insn", 32'(ev), 32'd10);
            end
            check("scie_insn", bus_a.scie_insn, e_insn);
            check("scie_rs1",  bus_a.scie_rs1,  e_rs1);
            check("scie_rs2",  bus_a.scie_rs2,  e_rs2);
            ev++;
            if (ev == abort_ev) return;
         end
         if (bus_a.out_valid) begin
            got_out = 1'b1;
            bus_a.in_valid = 1'b0;
            check("job_latency",  32'(cyc - acc_cyc), 32'd4);
            check("insn_count",   32'(ev),            32'd11);
            check("out_data",     bus_a.out_data,     REF_RESULT);
         end
      end
      check("job_done_in_budget", 32'(got_out), 32'd1);
   endtask

   initial begin
      int  eb, acc_cyc_b;
      bit  acc_b, done_b;
      logic [31:0] prev;

      bus_a.in_valid = 1'b0; bus_a.in_re = '0; bus_a.in_im = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_re = '0; bus_b.in_im = '0; bus_b.out_ready = 1'b0;

      // Reset values
      #12;
      check_a_cleared("reset");
      check("reset_b_valid", 32'(bus_b.scie_valid), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      step();
      check("post_reset_in_ready", 32'(bus_a.in_ready), 32'd1);

      // Reference job, in_valid held high, result held back afterwards
      run_job(1'b0, -1);
      bus_a.in_valid = 1'b1;
      bus_a.in_re    = tap_re[0];
      bus_a.in_im    = tap_im[0];
      prev = bus_a.out_data;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_out_valid",  32'(bus_a.out_valid),  32'd1);
         check("bp_out_data",   bus_a.out_data,        prev);
         check("bp_in_ready",   32'(bus_a.in_ready),   32'd0);
         check("bp_scie_valid", 32'(bus_a.scie_valid), 32'd0);
      end
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      step();
      bus_a.out_ready = 1'b0;
      check("release_out_valid", 32'(bus_a.out_valid), 32'd0);
      check("release_in_ready",  32'(bus_a.in_ready),  32'd1);

      // Bubbly input; consumer already ready when OUT is entered
      bus_a.out_ready = 1'b1;
      run_job(1'b1, -1);
      step();
      bus_a.out_ready = 1'b0;
      check("early_ready_taken", 32'(bus_a.out_valid), 32'd0);
      check("early_ready_idle",  32'(bus_a.in_ready),  32'd1);

      // Reset right after the third tap's LOAD_RE
      run_job(1'b0, 5);
      bus_a.in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_a_cleared("midreset");
      @(negedge clock);
      reset = 1'b0;
      run_job(1'b0, -1);
      bus_a.out_ready = 1'b1;
      step();
      bus_a.out_ready = 1'b0;
      check("after_reset_job_taken", 32'(bus_a.out_valid), 32'd0);

      // TAPS=1, RESULT_LAT=3 instance
      eb = 0; acc_cyc_b = 0; done_b = 1'b0;
      bus_b.in_valid = 1'b1;
      bus_b.in_re    = 32'sd100;
      bus_b.in_im    = -32'sd200;
      for (int k = 0; k < 40 && !done_b; k++) begin
         acc_b = bus_b.in_valid && bus_b.in_ready;
         step();
         if (acc_b) begin
            acc_cyc_b      = cyc;
            bus_b.in_valid = 1'b0;
         end
         if (bus_b.scie_valid) begin
            case (eb)
               0: begin
                  check("b_insn0", bus_b.scie_insn, LOAD_RE);
                  check("b_rs1_0", bus_b.scie_rs1,  32'd100);
               end
               1: begin
                  check("b_insn1", bus_b.scie_insn, LOAD_IM);
                  check("b_rs1_1", bus_b.scie_rs1,  -32'sd200);
               end
               2: begin
                  check("b_insn2", bus_b.scie_insn, COMPUTE);
                  check("b_rs1_2", bus_b.scie_rs1,  -32'sd200);
               end
               default: check("b_extra_insn", 32'(eb), 32'd2);
            endcase
            check("b_rs2", bus_b.scie_rs2, 32'd0);
            eb++;
         end
         if (bus_b.out_valid) begin
            done_b = 1'b1;
            check("b_latency",    32'(cyc - acc_cyc_b), 32'd6);
            check("b_insn_count", 32'(eb),              32'd3);
            check("b_out_data",   bus_b.out_data,       SWP_RESULT);
         end
      end
      check("b_done_in_budget", 32'(done_b), 32'd1);
      bus_b.out_ready = 1'b1;
      step();
      bus_b.out_ready = 1'b0;
      check("b_taken",    32'(bus_b.out_valid), 32'd0);
      check("b_in_ready", 32'(bus_b.in_ready),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_scie_fir_driver
